// File: rtl/gcd_method_responder_pkg.sv
// Shared types and constants for the gcd method responder (GCD_CYCLES_EN adds the cycle counter).
package gcd_method_pkg;

    localparam int GCD_DEFAULT_W = 32;
    localparam int GCD_CYC_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [GCD_CYC_W-1:0] sat_inc(input logic [GCD_CYC_W-1:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gcd_method_responder_if.sv
// Method-call bundle for gcd(a, b); gcd_cycles exists only when GCD_CYCLES_EN is defined.
interface gcd_method_responder_if
    import gcd_method_pkg::*;
#(
    parameter int W = GCD_DEFAULT_W
);
    logic                 gcd_req;
    logic [W-1:0]         gcd_a;
    logic [W-1:0]         gcd_b;
    logic                 gcd_busy;
    logic [W-1:0]         gcd_return;
`ifdef GCD_CYCLES_EN
    logic [GCD_CYC_W-1:0] gcd_cycles;
`endif

    modport master (
        output gcd_req,
        output gcd_a,
        output gcd_b,
        input  gcd_busy,
        input  gcd_return
`ifdef GCD_CYCLES_EN
        ,
        input  gcd_cycles
`endif
    );

    modport slave (
        input  gcd_req,
        input  gcd_a,
        input  gcd_b,
        output gcd_busy,
        output gcd_return
`ifdef GCD_CYCLES_EN
        ,
        output gcd_cycles
`endif
    );

endinterface

// File: rtl/gcd_method_responder_step.sv
// Purpose: one subtraction-GCD evaluation, priority a==0, b==0, a==b, a>b, else.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the step.
module gcd_step
    import gcd_method_pkg::*;
#(
    parameter int W = GCD_DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] next_a,
    output logic [W-1:0] next_b,
    output logic         done,
    output logic [W-1:0] result
);

    always_comb begin
        next_a = a;
        next_b = b;
        done   = 1'b0;
        result = '0;
        if (a == '0) begin
            done   = 1'b1;
            result = b;
        end else if (b == '0) begin
            done   = 1'b1;
            result = a;
        end else if (a == b) begin
            done   = 1'b1;
            result = a;
        end else if (a > b) begin
            next_a = a - b;
        end else begin
            next_b = b - a;
        end
    end

endmodule

// File: rtl/gcd_method_responder.sv
// Purpose: callee side of the gcd method handshake; optional GCD_CYCLES_EN reports RUN cycles.
// Latency: busy for (subtractions + 1) cycles, result visible the cycle busy falls.
// Backpressure: a held-high req parks in DONE; a new call needs req low for one cycle.
module gcd_method_responder
    import gcd_method_pkg::*;
#(
    parameter int W = GCD_DEFAULT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    gcd_method_responder_if.slave  bus
);

    gcd_state_t state;
    gcd_state_t state_nxt;

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] ret_q;

    logic [W-1:0] step_next_a;
    logic [W-1:0] step_next_b;
    logic         step_done;
    logic [W-1:0] step_result;

    gcd_step #(.W(W)) u_step (
        .a      (a_q),
        .b      (b_q),
        .next_a (step_next_a),
        .next_b (step_next_b),
        .done   (step_done),
        .result (step_result)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bus.gcd_req) state_nxt = ST_RUN;
            ST_RUN:  if (step_done)   state_nxt = ST_DONE;
            ST_DONE: if (!bus.gcd_req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            ret_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.gcd_req) begin
                        a_q <= bus.gcd_a;
                        b_q <= bus.gcd_b;
                    end
                end
                ST_RUN: begin
                    // Operands freeze on the terminating step; only the result moves.
                    if (step_done) begin
                        ret_q <= step_result;
                    end else begin
                        a_q <= step_next_a;
                        b_q <= step_next_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gcd_busy   = (state == ST_RUN);
    assign bus.gcd_return = ret_q;

`ifdef GCD_CYCLES_EN
    logic [GCD_CYC_W-1:0] cyc_cnt;
    logic [GCD_CYC_W-1:0] cyc_q;

    // The terminating evaluation is itself a RUN cycle, so it is included in the published count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            cyc_q   <= '0;
        end else begin
            if (state == ST_IDLE && bus.gcd_req) begin
                cyc_cnt <= '0;
            end else if (state == ST_RUN) begin
                cyc_cnt <= sat_inc(cyc_cnt);
                if (step_done) cyc_q <= sat_inc(cyc_cnt);
            end
        end
    end

    assign bus.gcd_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_method_responder.sv
// Directed bench for gcd_method_responder at W=8 with a queue of expected results.
module tb_gcd_method_responder;

    localparam int W = 8;

    logic clk;
    logic reset;

    gcd_method_responder_if #(.W(W)) bus ();

    gcd_method_responder #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned ret;
        int unsigned busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: result via Euclid remainder, busy length via counting subtractions.
    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t e;
        int unsigned x, y, t, subs;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        e.ret = x;
        x = a; y = b; subs = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) x = x - y; else y = y - x;
            subs++;
        end
        e.busy = subs + 1;
        return e;
    endfunction

    task automatic do_call(input string tag, input int unsigned a, input int unsigned b,
                           input bit hold, input int toggle_at);
        exp_t e;
        int   n;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, bus.gcd_busy}, 32'd0);
        bus.gcd_req = 1'b1;
        bus.gcd_a   = W'(a);
        bus.gcd_b   = W'(b);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.gcd_busy !== 1'b1) break;
            n++;
            if (n == toggle_at) begin
                bus.gcd_a = bus.gcd_a ^ 8'h5A;
                bus.gcd_b = bus.gcd_b ^ 8'h0F;
            end
            if (n >= 1000) break;
        end
        e = exp_q.pop_front();
        check({tag, "_busy_cycles"}, n, e.busy);
        check({tag, "_return"}, {24'd0, bus.gcd_return}, e.ret);
`ifdef GCD_CYCLES_EN
        check({tag, "_cycles"}, {16'd0, bus.gcd_cycles}, (e.busy > 65535) ? 65535 : e.busy);
`endif
        if (!hold) bus.gcd_req = 1'b0;
    endtask

    initial begin
        int rises;
        reset       = 1'b0;
        bus.gcd_req = 1'b0;
        bus.gcd_a   = '0;
        bus.gcd_b   = '0;

        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                check("rst_busy", {31'd0, bus.gcd_busy}, 32'd0);
                check("rst_return", {24'd0, bus.gcd_return}, 32'd0);
            end
        end
`ifdef GCD_CYCLES_EN
        check("rst_cycles", {16'd0, bus.gcd_cycles}, 32'd0);
`endif
        reset = 1'b1;

        do_call("g48_18", 48, 18, 1'b0, 0);
        check("g48_18_const", {24'd0, bus.gcd_return}, 32'd6);
        do_call("g0_7", 0, 7, 1'b0, 0);
        do_call("g0_0", 0, 0, 1'b0, 0);
        do_call("g9_0", 9, 0, 1'b0, 0);

        do_call("g21_14", 21, 14, 1'b1, 0);
        rises = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gcd_busy !== 1'b0) rises++;
            bus.gcd_a = W'($urandom_range(1, 255));
            bus.gcd_b = W'($urandom_range(1, 255));
        end
        check("held_req_busy_rises", rises, 0);
        check("held_req_return", {24'd0, bus.gcd_return}, 32'd7);
        bus.gcd_req = 1'b0;

        do_call("g1_255", 1, 255, 1'b0, 100);

        // Abort a call with reset: nothing partial may be published.
        @(negedge clk);
        bus.gcd_req = 1'b1;
        bus.gcd_a   = 8'd100;
        bus.gcd_b   = 8'd75;
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy", {31'd0, bus.gcd_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, bus.gcd_busy}, 32'd0);
        check("midrun_rst_return", {24'd0, bus.gcd_return}, 32'd0);
`ifdef GCD_CYCLES_EN
        check("midrun_rst_cycles", {16'd0, bus.gcd_cycles}, 32'd0);
`endif
        bus.gcd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        do_call("g100_75", 100, 75, 1'b0, 0);
        do_call("g12_8", 12, 8, 1'b0, 0);
        do_call("g17_5", 17, 5, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_method_responder.md
Name: gcd_method_responder

Overview:
- Synthesizable responder (callee) side of the compiler's method-call handshake (`<method>_req` / `<method>_busy` / `<method>_return`), implementing method `gcd(a, b)`.
- Calling FSMs and simulation benches raise `gcd_req` with arguments, poll `gcd_busy`, then sample `gcd_return`.
- Computes the greatest common divisor by iterative subtraction, one step per clock.

Parameters:
- W, 32, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Low = reset asserted.
- gcd_req  in  1  call request; level, held by the caller.
- gcd_a  in  W  first argument; sampled only when a call is accepted.
- gcd_b  in  W  second argument; sampled only when a call is accepted.
- gcd_busy  out  1  high while a call is in progress.
- gcd_return  out  W  result of the last completed call.
- gcd_cycles  out  16  RUN cycles used by the last call; present only with GCD_CYCLES_EN.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, gcd_busy=0, gcd_return=0, internal a/b=0, gcd_cycles=0.
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - gcd_req=1 at a rising edge → latch gcd_a/gcd_b into a/b and go to RUN.
  - gcd_busy=1 from the next cycle.
  - gcd_return keeps its previous value.
- RUN: one evaluation per cycle, in priority order:
  - a==0 → result=b, terminate.
  - b==0 → result=a, terminate.
  - a==b → result=a, terminate.
  - a>b → a<=a-b, stay in RUN.
  - otherwise → b<=b-a, stay in RUN.
  - On terminate: gcd_return<=result, gcd_busy<=0, go to DONE. The result is visible the cycle after the terminating evaluation.
- Latency:
  - gcd_busy stays high for exactly (subtraction count + 1) cycles.
  - Example: gcd(48,18): 48,18 → 30,18 → 12,18 → 12,6 → 6,6 → terminate = 5 busy cycles, return 6.
- DONE:
  - gcd_busy=0; gcd_return stable.
  - Stay in DONE while gcd_req=1; gcd_req=0 → IDLE.
  - A held-high req therefore never re-triggers a call. A new call needs req low for at least one cycle.
- Arguments: changes on gcd_a/gcd_b during RUN are ignored.
- gcd_req drop during RUN: ignored; the call completes normally.
- Arithmetic: unsigned, W bits. Subtraction never underflows because it is guarded by the compare.
- Edge cases:
  - gcd(0,0) returns 0 after 1 busy cycle.
  - gcd(x,0) and gcd(0,x) return x after 1 busy cycle.
- Worst-case latency: gcd(1, 2^W−1) gives 2^W−2 subtractions. Callers must tolerate data-dependent latency.
- Reset during RUN: immediate return to reset values. No partial result is published.
- Caller rule: gcd_busy is valid from the cycle after req is first sampled high. Callers must not decide completion in the same cycle they raise req.

Optional Feature:
- Macro: GCD_CYCLES_EN.
- Defined:
  - 16-bit counter cleared on call acceptance; increments each RUN cycle, saturating at 0xFFFF.
  - Copied to gcd_cycles on terminate, in the same cycle as gcd_return.
  - Reset value 0.
- Undefined: gcd_cycles port and counter are absent. All other behaviour is identical.

Decomposition:
- Package gcd_method_pkg holds:
  - state typedef (IDLE/RUN/DONE);
  - default width constant;
  - cycle-counter width constant (16).
- Sub-module gcd_step (combinational):
  - inputs a, b;
  - outputs next_a, next_b, done, result, implementing the RUN priority rules.
- The top level holds the FSM, registers and the optional counter.

Test Plan:
- Reset low for cycles 3..8 with req=0 → busy=0, return=0 throughout. Release reset, req=1, a=48, b=18 → busy high for exactly 5 cycles, then busy=0, return=6. With GCD_CYCLES_EN, cycles=5.
- a=0, b=7 → busy high 1 cycle, return=7. Then a=0, b=0 (req low 1 cycle between calls) → return=0.
- req held high permanently after the first call (a=21, b=14) → return=7. Busy never rises again. Change a/b while in DONE → return remains 7.
- a=1, b=255, W=8 → 254 subtractions, busy high 255 cycles, return=1. Toggle gcd_a mid-run → no effect.
- Assert reset mid-RUN during gcd(100,75) → busy=0, return=0 immediately (asynchronous). A new gcd(100,75) after release → return=25, busy 4 cycles.
- Back-to-back calls (req low 1 cycle between): gcd(12,8) then gcd(17,5) → returns 4 then 1. Busy is low for at least 2 cycles between calls.
